mult_unit: RTL and testbench

Iterative radix-2 shift-add multiplier for MULT/MULTU. It sits beside the EX-stage ALU/subtractor and writes the HI/LO result pair. It is the additive counterpart of the datapath's subtract logic: one conditional add and shift per cycle, 32 iterations per operation. The stall/hazard logic holds the pipeline while busy is high; a flush kills an in-flight operation via cancel.

---
 rtl/mult_unit.sv | 190 +++++++++++++++++++
 tb/tb_mult_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for MULT/MULTU.
// One conditional add and right shift per cycle. The hi/lo pair is written
// 33 edges after an accepted start. Signed operands are multiplied as
// magnitudes, and the product is negated at the end when the operand signs differ.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        count_r;
  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 accept_s;
  logic                 commit_s;
  logic                 busy_next_s;
  logic                 done_next_s;
  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   result_s;

  // Magnitude of an operand. The most negative value maps onto itself and is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    logic [WIDTH-1:0] m;
    if (sgn && v[WIDTH-1]) begin
      m = ~v + WIDTH'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. A flush aborts CALC or FINISH. Start is only honoured in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cancel) begin
          next_state_s = IDLE;
        end else if (count_r == LAST_ITER) begin
          next_state_s = FINISH;
        end else begin
          next_state_s = CALC;
        end
      end
      FINISH: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode: operand capture, result commit, and next values of busy/done.
  always_comb begin
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    busy_next_s = (next_state_s != IDLE);
    case (state_r)
      IDLE: begin
        accept_s = start;
      end
      FINISH: begin
        commit_s = ~cancel;
      end
      default: begin
        accept_s = 1'b0;
        commit_s = 1'b0;
      end
    endcase
    done_next_s = commit_s;
  end

  // One iteration: add the multiplicand into the upper half when the multiplier LSB is set.
  always_comb begin
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    if (neg_r) begin
      result_s = ~acc_r + (2*WIDTH)'(1);
    end else begin
      result_s = acc_r;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

  // Datapath. Operands load only on an accepted start, so later input changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r  <= magnitude(data1, is_signed);
            mplier_r <= magnitude(data2, is_signed);
            neg_r    <= is_signed & (data1[WIDTH-1] ^ data2[WIDTH-1]);
            acc_r    <= {(2*WIDTH){1'b0}};
            count_r  <= {CW{1'b0}};
          end
        end
        CALC: begin
          acc_r    <= {sum_s, acc_r[WIDTH-1:1]};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + CW'(1);
        end
        FINISH: begin
          if (commit_s) begin
            hi_r <= result_s[2*WIDTH-1:WIDTH];
            lo_r <= result_s[WIDTH-1:0];
          end
        end
        default: begin
          count_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit. Stimulus pushes the expected {hi,lo} and
// the due cycle. A negedge monitor pops the entry on every done pulse and checks it.
module tb_mult_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   tests;
  int   failed;
  int   cyc;
  logic prev_done;

  mult_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .data1(data1), .data2(data2), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", {63'd0, done}, 64'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("product", {hi, lo}, e.prod);
          check("latency", 64'(cyc), 64'(e.due));
        end
      end
      prev_done = done;
    end
  end

  // mode 0: plain op; 1: re-assert start with other operands at cycle 'at';
  // 2: cancel at cycle 'at' (exp is then the hi/lo that must survive).
  // Returns at the negedge of the done cycle, so a following call starts back-to-back.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [63:0] exp, input int mode, input int at);
    exp_t e;
    start     = 1'b1;
    data1     = a;
    data2     = b;
    is_signed = s;
    if (mode != 2) begin
      e.prod = exp;
      e.due  = cyc + 34;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      start  = 1'b0;
      cancel = 1'b0;
      if (k == 1) check("busy_after_start", {63'd0, busy}, 64'd1);
      if (mode == 1 && k == at) begin
        start     = 1'b1;
        data1     = ~a;
        data2     = 32'h0000_0005;
        is_signed = ~s;
      end
      if (mode == 2 && k == at) cancel = 1'b1;
      if (mode == 2 && k == at + 1) check("busy_after_cancel", {63'd0, busy}, 64'd0);
      if (mode == 2 && k == 34) check("hilo_kept", {hi, lo}, exp);
      if (mode != 2 && k == 33) check("busy_before_finish", {63'd0, busy}, 64'd1);
      if (mode != 2 && k == 34) check("busy_in_done", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    cyc       = 0;
    prev_done = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    cancel    = 1'b0;
    is_signed = 1'b0;
    data1     = 32'h0;
    data2     = 32'h0;
    #3;
    check("reset_state", {62'd0, busy, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 0);
    op(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0, 0);
    op(32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000, 0, 0);
    op(32'h0000_03E8, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_0BB8, 1, 10);
    op(32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F, 0, 0);
    op(32'h0000_0006, 32'h0000_0007, 1'b0, 64'h0000_0000_0000_002A, 0, 0);
    op(32'h0000_0009, 32'h0000_0009, 1'b0, 64'h0000_0000_0000_002A, 2, 20);
    op(32'h0000_000B, 32'h0000_000B, 1'b0, 64'h0000_0000_0000_002A, 2, 33);

    // Asynchronous reset in the middle of CALC, between clock edges.
    start = 1'b1;
    data1 = 32'h0000_0010;
    data2 = 32'h0000_0010;
    is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_state", {62'd0, busy, done}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op(32'h0000_0002, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_0006, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
